// File: rtl/req_arbiter_fsm_pkg.sv
// Shared state encoding, grant codes and requester identifiers for the
// two-requester arbiter.
package req_arbiter_fsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GA   = 2'd1,
    ST_GB   = 2'd2
  } arb_state_t;

  typedef enum logic {
    SIDE_A = 1'b0,
    SIDE_B = 1'b1
  } side_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_A    = 2'b01;
  localparam logic [1:0] GNT_B    = 2'b10;

  // The one-hot grant is derived from the state alone, so 2'b11 cannot occur.
  function automatic logic [1:0] gnt_decode(arb_state_t s);
    logic [1:0] g;
    g = GNT_NONE;
    case (s)
      ST_GA:   g = GNT_A;
      ST_GB:   g = GNT_B;
      default: g = GNT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at MAX; clr has priority over en.
// Used as the grant hold counter of req_arbiter_fsm.
module sat_counter #(
  parameter int W   = 3,
  parameter int MAX = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] QMAX = W'(MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != QMAX)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/req_arbiter_fsm.sv
// Round-robin grant controller for two requesters with a bounded hold time,
// so a waiting requester is served after at most HOLD_MAX cycles.
module req_arbiter_fsm
  import req_arbiter_fsm_pkg::*;
#(
  parameter int HOLD_MAX   = 4,
  parameter int CNT_W      = 3,
  parameter int FIXED_PRIO = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             release_pulse,
  output logic [CNT_W-1:0] hold_cnt
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  arb_state_t state;
  arb_state_t state_next;
  side_t      last;
  logic       release_evt;
  logic       cnt_en;
  logic       cnt_clr;

  always_comb begin
    state_next  = state;
    release_evt = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req_a && req_b) begin
          state_next = ((FIXED_PRIO != 0) || (last == SIDE_B)) ? ST_GA : ST_GB;
        end else if (req_a) begin
          state_next = ST_GA;
        end else if (req_b) begin
          state_next = ST_GB;
        end
      end
      ST_GA: begin
        if (!req_a || (req_b && (hold_cnt == HOLD_LAST))) begin
          release_evt = 1'b1;
          state_next  = req_b ? ST_GB : ST_IDLE;
        end
      end
      ST_GB: begin
        if (!req_b || (req_a && (hold_cnt == HOLD_LAST))) begin
          release_evt = 1'b1;
          state_next  = req_a ? ST_GA : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Count only while the same grant is kept; any new grant or idle restarts at 0.
  assign cnt_en  = (state_next == state) && (state != ST_IDLE);
  assign cnt_clr = !cnt_en;

  sat_counter #(
    .W   (CNT_W),
    .MAX (HOLD_MAX - 1)
  ) u_hold_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .q   (hold_cnt)
  );

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      last          <= SIDE_B;
      gnt           <= GNT_NONE;
      busy          <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_next;
      gnt           <= gnt_decode(state_next);
      busy          <= (state_next != ST_IDLE);
      release_pulse <= release_evt;
      if (release_evt) begin
        last <= (state == ST_GA) ? SIDE_A : SIDE_B;
      end
    end
  end

endmodule

// File: tb/tb_req_arbiter_fsm.sv
// Directed self-checking bench for req_arbiter_fsm: a default instance,
// a fixed-priority instance and a HOLD_MAX=1 instance share clock and reset.
module tb_req_arbiter_fsm;

  logic       clk;
  logic       rst;
  logic       req_a, req_b;
  logic       fa, fb;
  logic       ha, hb;
  logic [1:0] gnt, gnt_fp, gnt_h1;
  logic       busy, busy_fp, busy_h1;
  logic       pulse, pulse_fp, pulse_h1;
  logic [2:0] hold, hold_fp;
  logic [0:0] hold_h1;

  int checks = 0;
  int passes = 0;

  req_arbiter_fsm #(.HOLD_MAX(4), .CNT_W(3), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .busy(busy), .release_pulse(pulse), .hold_cnt(hold)
  );

  req_arbiter_fsm #(.HOLD_MAX(4), .CNT_W(3), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst), .req_a(fa), .req_b(fb),
    .gnt(gnt_fp), .busy(busy_fp), .release_pulse(pulse_fp), .hold_cnt(hold_fp)
  );

  req_arbiter_fsm #(.HOLD_MAX(1), .CNT_W(1), .FIXED_PRIO(0)) dut_h1 (
    .clk(clk), .rst(rst), .req_a(ha), .req_b(hb),
    .gnt(gnt_h1), .busy(busy_h1), .release_pulse(pulse_h1), .hold_cnt(hold_h1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_a = 0; req_b = 0; fa = 0; fb = 0; ha = 0; hb = 0;
    tick(); tick();
    checks++; if (gnt !== 2'b00) $display("[TB] FAIL reset_gnt: got %b expected 00", gnt); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passes++;
    checks++; if (hold !== 3'd0) $display("[TB] FAIL reset_hold: got %0d expected 0", hold); else passes++;
    checks++; if (pulse !== 1'b0) $display("[TB] FAIL reset_pulse: got %b expected 0", pulse); else passes++;
    checks++; if (gnt_fp !== 2'b00) $display("[TB] FAIL reset_gnt_fp: got %b expected 00", gnt_fp); else passes++;
    checks++; if (gnt_h1 !== 2'b00) $display("[TB] FAIL reset_gnt_h1: got %b expected 00", gnt_h1); else passes++;
    rst = 1'b0;
  endtask

  task automatic test_single_grant();
    req_a = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      checks++; if (gnt !== 2'b01) $display("[TB] FAIL single_gnt c%0d: got %b expected 01", c, gnt); else passes++;
      checks++; if (busy !== 1'b1) $display("[TB] FAIL single_busy c%0d: got %b expected 1", c, busy); else passes++;
      checks++; if (pulse !== 1'b0) $display("[TB] FAIL single_pulse c%0d: got %b expected 0", c, pulse); else passes++;
      checks++; if (hold !== 3'((c - 1 > 3) ? 3 : c - 1)) $display("[TB] FAIL single_hold c%0d: got %0d expected %0d", c, hold, (c - 1 > 3) ? 3 : c - 1); else passes++;
    end
    req_a = 1'b0;
    tick();
    checks++; if (gnt !== 2'b00) $display("[TB] FAIL single_release_gnt: got %b expected 00", gnt); else passes++;
    checks++; if (pulse !== 1'b1) $display("[TB] FAIL single_release_pulse: got %b expected 1", pulse); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL single_release_busy: got %b expected 0", busy); else passes++;
    checks++; if (hold !== 3'd0) $display("[TB] FAIL single_release_hold: got %0d expected 0", hold); else passes++;
    tick();
    checks++; if (pulse !== 1'b0) $display("[TB] FAIL single_pulse_width: got %b expected 0", pulse); else passes++;
  endtask

  // A was served last, so a simultaneous request from IDLE must go to B.
  task automatic test_round_robin_tie();
    logic [1:0] eg;
    req_a = 1'b1; req_b = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      eg = (c <= 4) ? 2'b10 : 2'b01;
      checks++; if (gnt !== eg) $display("[TB] FAIL rr_gnt c%0d: got %b expected %b", c, gnt, eg); else passes++;
      checks++; if (hold !== 3'((c <= 4) ? c - 1 : 0)) $display("[TB] FAIL rr_hold c%0d: got %0d expected %0d", c, hold, (c <= 4) ? c - 1 : 0); else passes++;
      checks++; if (pulse !== (c == 5)) $display("[TB] FAIL rr_pulse c%0d: got %b expected %b", c, pulse, c == 5); else passes++;
    end
    req_a = 1'b0; req_b = 1'b0;
    tick(); tick();
  endtask

  task automatic test_preempt_alternation();
    logic [1:0] eg;
    logic       ep;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_a = 1'b1; req_b = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      eg = (((c - 1) / 4) % 2 == 0) ? 2'b01 : 2'b10;
      ep = (c > 1) && ((c - 1) % 4 == 0);
      checks++; if (gnt !== eg) $display("[TB] FAIL alt_gnt c%0d: got %b expected %b", c, gnt, eg); else passes++;
      checks++; if (pulse !== ep) $display("[TB] FAIL alt_pulse c%0d: got %b expected %b", c, pulse, ep); else passes++;
      checks++; if (hold !== 3'((c - 1) % 4)) $display("[TB] FAIL alt_hold c%0d: got %0d expected %0d", c, hold, (c - 1) % 4); else passes++;
    end
    req_a = 1'b0; req_b = 1'b0;
    tick(); tick();
  endtask

  task automatic test_saturation();
    req_a = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      checks++; if (gnt !== 2'b01) $display("[TB] FAIL sat_gnt c%0d: got %b expected 01", c, gnt); else passes++;
      checks++; if (hold !== 3'((c - 1 > 3) ? 3 : c - 1)) $display("[TB] FAIL sat_hold c%0d: got %0d expected %0d", c, hold, (c - 1 > 3) ? 3 : c - 1); else passes++;
    end
    req_b = 1'b1;
    tick();
    checks++; if (gnt !== 2'b10) $display("[TB] FAIL sat_handover_gnt: got %b expected 10", gnt); else passes++;
    checks++; if (hold !== 3'd0) $display("[TB] FAIL sat_handover_hold: got %0d expected 0", hold); else passes++;
    checks++; if (pulse !== 1'b1) $display("[TB] FAIL sat_handover_pulse: got %b expected 1", pulse); else passes++;
    req_a = 1'b0; req_b = 1'b0;
    tick(); tick();
  endtask

  task automatic test_fixed_prio();
    logic [1:0] eg;
    for (int round = 0; round < 2; round++) begin
      if (round == 1) begin
        fa = 1'b1;
        tick();
        fa = 1'b0;
        tick();
      end
      fa = 1'b1; fb = 1'b1;
      for (int c = 1; c <= 5; c++) begin
        tick();
        eg = (c <= 4) ? 2'b01 : 2'b10;
        checks++; if (gnt_fp !== eg) $display("[TB] FAIL fp_gnt r%0d c%0d: got %b expected %b", round, c, gnt_fp, eg); else passes++;
      end
      fa = 1'b0; fb = 1'b0;
      tick(); tick();
    end
  endtask

  task automatic test_hold_one();
    logic [1:0] eg;
    ha = 1'b1; hb = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      eg = (c % 2 == 1) ? 2'b01 : 2'b10;
      checks++; if (gnt_h1 !== eg) $display("[TB] FAIL h1_gnt c%0d: got %b expected %b", c, gnt_h1, eg); else passes++;
      checks++; if (pulse_h1 !== (c > 1)) $display("[TB] FAIL h1_pulse c%0d: got %b expected %b", c, pulse_h1, c > 1); else passes++;
    end
    ha = 1'b0; hb = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_mid_grant();
    req_a = 1'b1; req_b = 1'b1;
    for (int c = 1; c <= 5; c++) tick();
    checks++; if (gnt !== 2'b10) $display("[TB] FAIL midrst_pre_gnt: got %b expected 10", gnt); else passes++;
    rst = 1'b1;
    tick();
    checks++; if (gnt !== 2'b00) $display("[TB] FAIL midrst_gnt: got %b expected 00", gnt); else passes++;
    checks++; if (pulse !== 1'b0) $display("[TB] FAIL midrst_pulse: got %b expected 0", pulse); else passes++;
    checks++; if (hold !== 3'd0) $display("[TB] FAIL midrst_hold: got %0d expected 0", hold); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %b expected 0", busy); else passes++;
    rst = 1'b0;
    tick();
    checks++; if (gnt !== 2'b01) $display("[TB] FAIL midrst_after_gnt: got %b expected 01", gnt); else passes++;
    checks++; if (pulse !== 1'b0) $display("[TB] FAIL midrst_after_pulse: got %b expected 0", pulse); else passes++;
    req_a = 1'b0; req_b = 1'b0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_round_robin_tie();
    test_preempt_alternation();
    test_saturation();
    test_fixed_prio();
    test_hold_one();
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
